mdu: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS core. It sits in the EX stage directly upstream of the HI/LO registers inside the register file. It accepts MULT/MULTU/DIV/DIVU from EX and stalls the pipeline while it iterates. It then delivers the 64-bit result as a one-cycle HI/LO write (`hi_we`/`lo_we`, `hi_data`/`lo_data`) that the register file consumes.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_step.sv | 29 ++
 rtl/mdu.sv | 143 ++++++++++++++
 tb/tb_mdu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mdu_pkg : op and state encodings for the multiply/divide unit      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mdu_div_step : one combinational restoring-divide iteration       |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Partial remainder is always below the divisor, so a successful
  // subtract leaves the top bit clear and a borrow always sets it.
  always_comb begin
    w_shift = {i_rem, i_dvd_bit};
    w_diff  = w_shift - {1'b0, i_divisor};
    o_q_bit = ~w_diff[WIDTH];
    o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mdu : multi-cycle MULT/MULTU/DIV/DIVU unit feeding HI/LO          |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data
);

  localparam int c_CNT_W = $clog2(WIDTH);

  mdu_state_e           r_state;
  mdu_state_e           w_state_next;
  mdu_op_e              r_op;
  mdu_op_e              w_op_in;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_step_rem;
  logic                 w_step_q;
  logic [WIDTH-1:0]     w_div_hi;
  logic [WIDTH-1:0]     w_div_lo;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_result;

  assign w_op_in  = mdu_op_e'(op);
  assign w_accept = (r_state == ST_IDLE) && start && !cancel;
  assign w_last   = (r_cnt == c_CNT_W'(WIDTH - 1));

  assign w_a_neg  = op_is_signed(w_op_in) && src_a[WIDTH-1];
  assign w_b_neg  = op_is_signed(w_op_in) && src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;

  // Multiply: accumulator high half gathers the product, low half shifts
  // the multiplier out one bit per cycle.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_dvd_bit (r_acc[WIDTH-1]),
    .i_divisor (r_opnd),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_step_q)
  );

  assign w_div_next = {w_step_rem, r_acc[WIDTH-2:0], w_step_q};
  assign w_acc_next = op_is_div(r_op) ? w_div_next : w_mul_next;

  // A zero divisor already yields remainder = |a| (fixed back to a) and an
  // all-ones quotient; only the quotient sign fix-up must be skipped.
  assign w_div_hi = r_neg_hi ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
  assign w_div_lo = (r_opnd == '0) ? '1
                  : (r_neg_lo ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0]);
  assign w_prod   = r_neg_lo ? -w_acc_next : w_acc_next;
  assign w_result = op_is_div(r_op) ? {w_div_hi, w_div_lo} : w_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (cancel) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start)  w_state_next = ST_CALC;
        ST_CALC: if (w_last) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= MDU_MULT;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept) begin
      r_op     <= w_op_in;
      r_cnt    <= '0;
      r_acc    <= op_is_div(w_op_in) ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
      r_opnd   <= op_is_div(w_op_in) ? w_b_mag : w_a_mag;
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_hi <= w_a_neg;
    end else if ((r_state == ST_CALC) && !cancel) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign hi_we   = (r_state == ST_DONE) && !cancel;
  assign lo_we   = hi_we;
  assign hi_data = r_hi;
  assign lo_data = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_mdu : self-checking bench for the multiply/divide unit         |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  int n_total = 0;
  int n_pass  = 0;

  mdu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .cancel  (cancel),
    .busy    (busy),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .hi_data (hi_data),
    .lo_data (lo_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain arithmetic on the architectural definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin q = sa * sb; res = q; end
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Issues one op from an idle negedge and watches 40 cycles of outputs.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int hi_cnt, lo_cnt, we_pos, busy_cnt;
    logic [63:0] got;
    hi_cnt = 0; lo_cnt = 0; we_pos = 0; busy_cnt = 0; got = '0;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cnt++;
      if (lo_we) lo_cnt++;
      if (hi_we) begin
        hi_cnt++;
        we_pos = n;
        got = {hi_data, lo_data};
      end
      if (n < 40) @(negedge clk);
    end
    chk({nm, " result"}, got, exp);
    chk({nm, " hi_we pulses"}, 64'(hi_cnt), 64'd1);
    chk({nm, " lo_we pulses"}, 64'(lo_cnt), 64'd1);
    chk({nm, " write cycle"}, 64'(we_pos), 64'd33);
    chk({nm, " busy cycles"}, 64'(busy_cnt), 64'd33);
  endtask

  initial begin
    logic [63:0] last_res;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          acc_cyc, n_acc;
    logic        last_busy;
    logic [1:0]  drv_o, acc_o;
    logic [31:0] drv_a, drv_b, acc_a, acc_b;

    vecs[0] = '{2'd0, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA};
    vecs[1] = '{2'd1, 32'hFFFFFFFE, 32'h00000003, 64'h00000002_FFFFFFFA};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{2'd3, 32'd100,      32'd7,        64'h00000002_0000000E};
    vecs[4] = '{2'd3, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF};
    vecs[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[6] = '{2'd2, 32'h80000001, 32'h00000000, 64'h80000001_FFFFFFFF};
    vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};

    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset we", {62'd0, hi_we, lo_we}, 64'd0);
    chk("reset data", {hi_data, lo_data}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    last_res = vecs[7].exp;

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      if ($urandom_range(0, 1) == 1) ra = {{16{ra[15]}}, ra[15:0]};
      last_res = model(ro, ra, rb);
      run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, last_res);
    end

    // Cancel on the 10th CALC cycle, then restart one cycle later.
    op = 2'd3; src_a = 32'hDEADBEEF; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", 64'(busy), 64'd0);
    chk("cancel data held", {hi_data, lo_data}, last_res);
    run_op("after cancel", 2'd0, 32'hFFFFFFF0, 32'd16, 64'hFFFFFFFF_FFFFFF00);

    // Cancel during the DONE cycle masks the write enables.
    op = 2'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    chk("done we before cancel", {62'd0, hi_we, lo_we}, 64'd3);
    cancel = 1'b1;
    #1;
    chk("done we masked", {62'd0, hi_we, lo_we}, 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    chk("done cancel busy", 64'(busy), 64'd0);

    // start held high with operands changing every cycle.
    acc_cyc = 0; n_acc = 0; last_busy = busy;
    acc_o = '0; acc_a = '0; acc_b = '0;
    drv_o = 2'($urandom_range(0, 3)); drv_a = $urandom; drv_b = $urandom;
    op = drv_o; src_a = drv_a; src_b = drv_b; start = 1'b1;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (!last_busy && busy) begin
        if (n_acc > 0) chk($sformatf("accept interval %0d", n_acc), 64'(cyc - acc_cyc), 64'd34);
        acc_cyc = cyc; n_acc++;
        acc_o = drv_o; acc_a = drv_a; acc_b = drv_b;
      end
      if (hi_we) chk($sformatf("held start result %0d", n_acc), {hi_data, lo_data}, model(acc_o, acc_a, acc_b));
      last_busy = busy;
      drv_o = 2'($urandom_range(0, 3)); drv_a = $urandom; drv_b = $urandom;
      op = drv_o; src_a = drv_a; src_b = drv_b;
    end
    start = 1'b0;
    chk("held start accepts", 64'(n_acc), 64'd4);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-CALC.
    run_op("pre reset", 2'd3, 32'd1000, 32'd3, 64'h00000001_0000014D);
    op = 2'd0; src_a = 32'h1234; src_b = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst we", {62'd0, hi_we, lo_we}, 64'd0);
    chk("async rst data", {hi_data, lo_data}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post reset idle", 64'(busy), 64'd0);
    run_op("post reset", 2'd2, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
